// File: rtl/ysyx_24110026_lsu.sv
// Load/store unit between execute and write-back: one outstanding access at a time.
// It aligns store data and strobes, sign- or zero-extends load data, and flags misaligned accesses.
module ysyx_24110026_lsu #(
  parameter int REGIDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_alu_out,
  input  logic [31:0]         in_rs2_data,
  input  logic [4:0]          in_ls_op,
  input  logic [REGIDX_W-1:0] in_rd,
  input  logic                in_wb_en,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_addr,
  output logic                mem_wen,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_wb_data,
  output logic [REGIDX_W-1:0] out_rd,
  output logic                out_wb_en,
  output logic                out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [31:0]         addr;
    logic [31:0]         rs2;
    logic [4:0]          op;
    logic [REGIDX_W-1:0] rd;
    logic                wb_en;
  } lsu_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        wb_en;
    logic        err;
  } lsu_rsp_t;

  state_t   state, state_nxt;
  lsu_req_t req_q;
  lsu_rsp_t rsp_q;

  // Decode of the incoming op, used only on the accept cycle.
  logic       in_ld, in_st, in_f3_ok, in_mem_op, in_misal, in_go_mem, accept;
  logic [2:0] in_f3;

  assign in_ld     = in_ls_op[4];
  assign in_st     = in_ls_op[3];
  assign in_f3     = in_ls_op[2:0];
  assign in_f3_ok  = (in_f3 == 3'b000) || (in_f3 == 3'b001) || (in_f3 == 3'b010) ||
                     (in_f3 == 3'b100) || (in_f3 == 3'b101);
  assign in_mem_op = (in_ld ^ in_st) && in_f3_ok;
  assign in_misal  = ((in_f3[1:0] == 2'b01) && in_alu_out[0]) ||
                     ((in_f3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
  assign in_go_mem = in_mem_op && !in_misal;
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)        state_nxt = in_go_mem ? REQ : DONE;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_rsp_valid) state_nxt = DONE;
      DONE: if (out_ready)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Load data extraction from the word-aligned read
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_sext;

  assign ld_byte = mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{req_q.addr[1], 4'b0000} +: 16];
  assign ld_sext = !req_q.op[2];

  always_comb begin
    ld_data = mem_rdata;
    case (req_q.op[1:0])
      2'b00:   ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Request capture and result formation
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q <= '0;
      rsp_q <= '0;
    end else if (accept) begin
      req_q.addr  <= in_alu_out;
      req_q.rs2   <= in_rs2_data;
      req_q.op    <= in_ls_op;
      req_q.rd    <= in_rd;
      req_q.wb_en <= in_wb_en;
      if (!in_ld && !in_st) begin
        rsp_q <= '{data: in_alu_out, wb_en: in_wb_en, err: 1'b0};
      end else if (!in_mem_op) begin
        rsp_q <= '{data: in_alu_out, wb_en: 1'b0, err: 1'b1};
      end else if (in_misal) begin
        rsp_q <= '{data: 32'd0, wb_en: 1'b0, err: 1'b1};
      end else begin
        rsp_q <= '0;
      end
    end else if (state == WAIT && mem_rsp_valid) begin
      if (req_q.op[4]) rsp_q <= '{data: ld_data, wb_en: req_q.wb_en, err: 1'b0};
      else             rsp_q <= '0;
    end
  end

  // Outputs: every port is forced to zero outside the state that owns it
  always_comb begin
    in_ready      = (state == IDLE) && rst;
    mem_req_valid = 1'b0;
    mem_addr      = 32'd0;
    mem_wen       = 1'b0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'b0000;
    out_valid     = 1'b0;
    out_wb_data   = 32'd0;
    out_rd        = '0;
    out_wb_en     = 1'b0;
    out_err       = 1'b0;
    if (state == REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = {req_q.addr[31:2], 2'b00};
      mem_wen       = req_q.op[3];
      if (req_q.op[3]) begin
        case (req_q.op[1:0])
          2'b00: begin
            mem_wstrb = 4'b0001 << req_q.addr[1:0];
            mem_wdata = {4{req_q.rs2[7:0]}};
          end
          2'b01: begin
            mem_wstrb = req_q.addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{req_q.rs2[15:0]}};
          end
          default: begin
            mem_wstrb = 4'b1111;
            mem_wdata = req_q.rs2;
          end
        endcase
      end
    end
    if (state == DONE) begin
      out_valid   = 1'b1;
      out_wb_data = rsp_q.data;
      out_rd      = req_q.rd;
      out_wb_en   = rsp_q.wb_en;
      out_err     = rsp_q.err;
    end
  end

endmodule
